// File: rtl/ecg_window_feeder_pkg.sv
// Shared layer constants and the window feeder state encoding.
package ecg_window_feeder_pkg;

    localparam int unsigned ACT_W      = 8;
    localparam int unsigned NODE_FANIN = 5;
    localparam int unsigned NODE_LAT   = 3;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        StFill,
        StPresent,
        StStep,
        StPad
    } feeder_state_e;

endpackage

// File: rtl/ecg_window_feeder_valid_delay_line.sv
// Fixed-latency shift register for strobe/flag alignment with a node pipeline.
module ecg_window_feeder_valid_delay_line #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/ecg_window_feeder.sv
// Serial sample stream to 5-wide sliding window with node-aligned valid/record-done strobes.
// Define FEEDER_ZERO_PAD_EN to zero-pad and present a truncated final window of a record.
module ecg_window_feeder #(
    parameter int unsigned NUM_IN   = ecg_window_feeder_pkg::NODE_FANIN,
    parameter int unsigned STRIDE   = 1,
    parameter int unsigned NODE_LAT = ecg_window_feeder_pkg::NODE_LAT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] A0x,
    output logic [7:0] A1x,
    output logic [7:0] A2x,
    output logic [7:0] A3x,
    output logic [7:0] A4x,
    output logic       a_valid,
    output logic       n_valid,
    output logic       rec_done
);

    import ecg_window_feeder_pkg::*;

`ifdef FEEDER_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(NUM_IN - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STRIDE - 1);

    feeder_state_e    r_state;
    feeder_state_e    w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rec_last;
    logic             r_live;
    logic [ACT_W-1:0] r_win [NUM_IN];
    logic             w_xfer;
    logic             w_fill_done;
    logic             w_step_done;
    logic             w_shift;
    logic [ACT_W-1:0] w_shift_data;
    logic [1:0]       w_dly_in;
    logic [1:0]       w_dly_out;

    assign w_xfer       = s_valid && s_ready;
    assign w_fill_done  = (r_cnt == FILL_LAST);
    assign w_step_done  = (r_cnt == STEP_LAST);
    assign w_shift      = w_xfer || (r_state == StPad);
    assign w_shift_data = w_xfer ? s_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFill;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFill: begin
                if (w_xfer) begin
                    if (w_fill_done) begin
                        w_state_next = StPresent;
                    end else if (s_last) begin
                        w_state_next = PAD_EN ? StPad : StFill;
                    end
                end
            end
            StStep: begin
                if (w_xfer) begin
                    if (w_step_done) begin
                        w_state_next = StPresent;
                    end else if (s_last) begin
                        w_state_next = PAD_EN ? StPad : StFill;
                    end
                end
            end
            StPresent: w_state_next = r_rec_last ? StFill : StStep;
            StPad: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = StPresent;
                end
            end
            default: w_state_next = StFill;
        endcase
    end

    // r_live keeps s_ready low for the first cycle after reset releases.
    always_comb begin
        s_ready = r_live && ((r_state == StFill) || (r_state == StStep));
        a_valid = (r_state == StPresent);
    end

    // In StPad r_cnt holds the number of zero samples still to insert.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_rec_last <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                StFill: begin
                    if (w_xfer) begin
                        if (w_fill_done) begin
                            r_cnt      <= '0;
                            r_rec_last <= s_last;
                        end else if (s_last) begin
                            r_cnt <= PAD_EN ? (FILL_LAST - r_cnt) : '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                StStep: begin
                    if (w_xfer) begin
                        if (w_step_done) begin
                            r_cnt      <= '0;
                            r_rec_last <= s_last;
                        end else if (s_last) begin
                            r_cnt <= PAD_EN ? (STEP_LAST - r_cnt) : '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                StPresent: begin
                    r_cnt      <= '0;
                    r_rec_last <= 1'b0;
                end
                StPad: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_rec_last <= 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_shift) begin
            for (int unsigned i = 0; i < NUM_IN - 1; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[NUM_IN-1] <= w_shift_data;
        end
    end

    assign A0x = r_win[0];
    assign A1x = r_win[1];
    assign A2x = r_win[2];
    assign A3x = r_win[3];
    assign A4x = r_win[4];

    assign w_dly_in = {a_valid, a_valid && r_rec_last};

    ecg_window_feeder_valid_delay_line #(
        .DEPTH (NODE_LAT),
        .WIDTH (2)
    ) u_dly (
        .i_clk   (clk),
        .i_reset (reset),
        .i_data  (w_dly_in),
        .o_data  (w_dly_out)
    );

    assign n_valid  = w_dly_out[1];
    assign rec_done = w_dly_out[0];

endmodule

// File: tb/tb_ecg_window_feeder.sv
// Directed bench for ecg_window_feeder: stride-1 and stride-2 instances share the stimulus.
module tb_ecg_window_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready, a_valid, n_valid, rec_done;
    logic [7:0] a0, a1, a2, a3, a4;
    logic       s_ready2, a_valid2, n_valid2, rec_done2;
    logic [7:0] b0, b1, b2, b3, b4;
    logic       sel = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int nready = 0;
    int stray = 0;
    logic [39:0] win_q[$];
    logic [39:0] w2_q[$];
    logic        rd_q[$];
    int          av_q[$];
    int          nv_q[$];
    int          av2_q[$];

    ecg_window_feeder #(.STRIDE(1)) dut (
        .clk (clk), .reset (reset), .s_data (s_data), .s_valid (s_valid), .s_last (s_last),
        .s_ready (s_ready), .A0x (a0), .A1x (a1), .A2x (a2), .A3x (a3), .A4x (a4),
        .a_valid (a_valid), .n_valid (n_valid), .rec_done (rec_done)
    );

    ecg_window_feeder #(.STRIDE(2)) dut2 (
        .clk (clk), .reset (reset), .s_data (s_data), .s_valid (s_valid), .s_last (s_last),
        .s_ready (s_ready2), .A0x (b0), .A1x (b1), .A2x (b2), .A3x (b3), .A4x (b4),
        .a_valid (a_valid2), .n_valid (n_valid2), .rec_done (rec_done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_valid) begin
            win_q.push_back({a0, a1, a2, a3, a4});
            av_q.push_back(cyc);
        end
        if (n_valid) begin
            nv_q.push_back(cyc);
            rd_q.push_back(rec_done);
        end
        if (rec_done && !n_valid) stray++;
        if (!reset && !s_ready && !a_valid) nready++;
        if (a_valid2) begin
            w2_q.push_back({b0, b1, b2, b3, b4});
            av2_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int i;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        i = 0;
        while (!(sel ? s_ready2 : s_ready) && i < 50) begin
            tick();
            i++;
        end
        if (i == 50) check("ready_timeout", 40'(sel ? s_ready2 : s_ready), 40'd1);
        tick();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        win_q.delete(); w2_q.delete(); rd_q.delete();
        av_q.delete(); nv_q.delete(); av2_q.delete();
        nready = 0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] exp_w [3];

        // Reset state and s_ready release timing.
        tick();
        tick();
        check("rst_win", {a0, a1, a2, a3, a4}, 40'h0);
        check("rst_a_valid", 40'(a_valid), 40'd0);
        check("rst_n_valid", 40'(n_valid), 40'd0);
        check("rst_rec_done", 40'(rec_done), 40'd0);
        check("rst_ready", 40'(s_ready), 40'd0);
        reset = 1'b0;
        check("ready_lag", 40'(s_ready), 40'd0);
        tick();
        check("ready_up", 40'(s_ready), 40'd1);
        win_q.delete(); av_q.delete(); nv_q.delete(); rd_q.delete();
        nready = 0;

        // Stride 1: stream 1..7 continuously.
        for (int v = 1; v <= 7; v++) send(8'(v), 1'b0);
        idle();
        wait_cycles(8);
        exp_w[0] = 40'h0102030405;
        exp_w[1] = 40'h0203040506;
        exp_w[2] = 40'h0304050607;
        check("s1_count", 40'(win_q.size()), 40'd3);
        for (int i = 0; i < 3 && i < win_q.size(); i++) check("s1_win", win_q[i], exp_w[i]);
        if (av_q.size() >= 3) begin
            check("s1_gap0", 40'(av_q[1] - av_q[0]), 40'd2);
            check("s1_gap1", 40'(av_q[2] - av_q[1]), 40'd2);
        end
        check("s1_nv_count", 40'(nv_q.size()), 40'd3);
        for (int i = 0; i < 3 && i < nv_q.size() && i < av_q.size(); i++)
            check("s1_nv_lat", 40'(nv_q[i] - av_q[i]), 40'd3);
        check("s1_ready_low", 40'(nready), 40'd0);

        // s_last completing a window, then a full refill.
        do_reset();
        for (int v = 1; v <= 4; v++) send(8'(v), 1'b0);
        send(8'd5, 1'b1);
        for (int v = 10; v <= 14; v++) send(8'(v), 1'b0);
        idle();
        wait_cycles(8);
        check("last_count", 40'(win_q.size()), 40'd2);
        if (win_q.size() >= 2) begin
            check("last_win0", win_q[0], 40'h0102030405);
            check("last_win1", win_q[1], 40'h0a0b0c0d0e);
            check("last_gap", 40'(av_q[1] - av_q[0]), 40'd6);
        end
        check("last_nv_count", 40'(nv_q.size()), 40'd2);
        if (rd_q.size() >= 2) begin
            check("last_rd0", 40'(rd_q[0]), 40'd1);
            check("last_rd1", 40'(rd_q[1]), 40'd0);
        end

        // s_last on a partial window.
        do_reset();
        send(8'd10, 1'b0);
        send(8'd11, 1'b0);
        send(8'd12, 1'b1);
        for (int v = 20; v <= 24; v++) send(8'(v), 1'b0);
        idle();
        wait_cycles(8);
`ifdef FEEDER_ZERO_PAD_EN
        check("part_count", 40'(win_q.size()), 40'd2);
        if (win_q.size() >= 2 && rd_q.size() >= 2) begin
            check("part_pad_win", win_q[0], 40'h0a0b0c0000);
            check("part_pad_rd", 40'(rd_q[0]), 40'd1);
            check("part_win", win_q[1], 40'h1415161718);
            check("part_rd", 40'(rd_q[1]), 40'd0);
        end
`else
        check("part_count", 40'(win_q.size()), 40'd1);
        if (win_q.size() >= 1 && rd_q.size() >= 1) begin
            check("part_win", win_q[0], 40'h1415161718);
            check("part_rd", 40'(rd_q[0]), 40'd0);
        end
`endif

        // Reset two cycles after a_valid.
        do_reset();
        for (int v = 1; v <= 5; v++) send(8'(v), 1'b0);
        idle();
        check("mid_present", 40'(a_valid), 40'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mid_win", {a0, a1, a2, a3, a4}, 40'h0);
        check("mid_a_valid", 40'(a_valid), 40'd0);
        check("mid_ready", 40'(s_ready), 40'd0);
        reset = 1'b0;
        wait_cycles(6);
        check("mid_no_nv", 40'(nv_q.size()), 40'd0);
        for (int v = 30; v <= 34; v++) send(8'(v), 1'b0);
        idle();
        wait_cycles(6);
        check("mid_count", 40'(win_q.size()), 40'd2);
        if (win_q.size() >= 2) check("mid_rebuild", win_q[1], 40'h1e1f202122);
        check("mid_nv_count", 40'(nv_q.size()), 40'd1);

        // Stride 2 instance: stream 1..9.
        sel = 1'b1;
        do_reset();
        for (int v = 1; v <= 9; v++) send(8'(v), 1'b0);
        idle();
        wait_cycles(8);
        exp_w[0] = 40'h0102030405;
        exp_w[1] = 40'h0304050607;
        exp_w[2] = 40'h0506070809;
        check("s2_count", 40'(w2_q.size()), 40'd3);
        for (int i = 0; i < 3 && i < w2_q.size(); i++) check("s2_win", w2_q[i], exp_w[i]);
        if (av2_q.size() >= 3) begin
            check("s2_gap0", 40'(av2_q[1] - av2_q[0]), 40'd3);
            check("s2_gap1", 40'(av2_q[2] - av2_q[1]), 40'd3);
        end

        check("stray_rec_done", 40'(stray), 40'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
